// File: rtl/trx_sequencer.sv
// TX/RX and band-switch sequencer: break-before-make band changes, timed key-up/unkey
// around the T/R switch, and an optional TX watchdog. All outputs are registered.
module trx_sequencer #(
  parameter int NUM_BANDS = 8,
  localparam int BW = $clog2(NUM_BANDS),
  parameter int CNT_W   = 32,
  parameter int T_BREAK = 240,
  parameter int T_BAND  = 240000,
  parameter int T_KEY   = 120000,
  parameter int T_UNKEY = 24000,
  parameter int T_RX    = 120000,
  parameter int TX_MAX  = 0
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 txReq,
  input  logic [BW-1:0]        bandReq,
  output logic [NUM_BANDS-1:0] bandSelect,
  output logic                 txEnable,
  output logic                 ncoEnable,
  output logic                 busy,
  output logic                 badBand,
  output logic                 txTimeout,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_RX          = 3'd0,
    S_BAND_BREAK  = 3'd1,
    S_BAND_SETTLE = 3'd2,
    S_TX_KEYUP    = 3'd3,
    S_TX_ON       = 3'd4,
    S_TX_UNKEY    = 3'd5,
    S_RX_SETTLE   = 3'd6
  } state_t;

  // Delay states load T-1 on entry and leave when the counter reads zero.
  localparam logic [CNT_W-1:0] LD_BREAK = CNT_W'(T_BREAK - 1);
  localparam logic [CNT_W-1:0] LD_BAND  = CNT_W'(T_BAND - 1);
  localparam logic [CNT_W-1:0] LD_KEY   = CNT_W'(T_KEY - 1);
  localparam logic [CNT_W-1:0] LD_UNKEY = CNT_W'(T_UNKEY - 1);
  localparam logic [CNT_W-1:0] LD_RX    = CNT_W'(T_RX - 1);
  localparam logic [CNT_W-1:0] LD_TXMAX = CNT_W'((TX_MAX == 0) ? 0 : TX_MAX - 1);
  localparam logic [BW:0]      NB       = (BW + 1)'(NUM_BANDS);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]          cur_band_q, cur_band_d;
  logic [BW-1:0]          new_band_q, new_band_d;
  logic [NUM_BANDS-1:0]   bs_d;
  logic                   tx_d, nco_d, to_d;
  logic                   band_ok, cnt_zero;

  assign band_ok  = ({1'b0, bandReq} < NB);
  assign cnt_zero = (cnt_q == '0);
  assign state    = state_q;

  // txReq is a level: holding it high asks for TX, dropping it at any point asks to unkey.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_band_d = cur_band_q;
    new_band_d = new_band_q;
    bs_d       = bandSelect;
    tx_d       = txEnable;
    nco_d      = ncoEnable;
    to_d       = txTimeout;
    case (state_q)
      S_RX: begin
        if (band_ok && (bandReq != cur_band_q)) begin
          state_d    = S_BAND_BREAK;
          cnt_d      = LD_BREAK;
          new_band_d = bandReq;
          bs_d       = '0;
        end else if (txReq && !txTimeout) begin
          state_d = S_TX_KEYUP;
          cnt_d   = LD_KEY;
          tx_d    = 1'b1;
        end else if (!txReq) begin
          to_d = 1'b0;
        end
      end
      S_BAND_BREAK: begin
        if (cnt_zero) begin
          state_d    = S_BAND_SETTLE;
          cnt_d      = LD_BAND;
          bs_d       = NUM_BANDS'(1) << new_band_q;
          cur_band_d = new_band_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_BAND_SETTLE: begin
        if (cnt_zero) state_d = S_RX;
        else          cnt_d   = cnt_q - CNT_W'(1);
      end
      S_TX_KEYUP: begin
        if (!txReq) begin
          state_d = S_TX_UNKEY;
          cnt_d   = LD_UNKEY;
        end else if (cnt_zero) begin
          state_d = S_TX_ON;
          cnt_d   = LD_TXMAX;
          nco_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_TX_ON: begin
        if (!txReq) begin
          state_d = S_TX_UNKEY;
          cnt_d   = LD_UNKEY;
          nco_d   = 1'b0;
        end else if (TX_MAX != 0) begin
          if (cnt_zero) begin
            state_d = S_TX_UNKEY;
            cnt_d   = LD_UNKEY;
            nco_d   = 1'b0;
            to_d    = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_TX_UNKEY: begin
        if (cnt_zero) begin
          state_d = S_RX_SETTLE;
          cnt_d   = LD_RX;
          tx_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RX_SETTLE: begin
        if (cnt_zero) state_d = S_RX;
        else          cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        // Unreachable code 7: fall back to the post-reset picture.
        state_d    = S_RX;
        cnt_d      = '0;
        cur_band_d = '0;
        new_band_d = '0;
        bs_d       = NUM_BANDS'(1);
        tx_d       = 1'b0;
        nco_d      = 1'b0;
        to_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= S_RX;
      cnt_q      <= '0;
      cur_band_q <= '0;
      new_band_q <= '0;
      bandSelect <= NUM_BANDS'(1);
      txEnable   <= 1'b0;
      ncoEnable  <= 1'b0;
      busy       <= 1'b0;
      badBand    <= 1'b0;
      txTimeout  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_band_q <= cur_band_d;
      new_band_q <= new_band_d;
      bandSelect <= bs_d;
      txEnable   <= tx_d;
      ncoEnable  <= nco_d;
      busy       <= (state_d != S_RX);
      badBand    <= !band_ok;
      txTimeout  <= to_d;
    end
  end

endmodule

// File: tb/tb_trx_sequencer.sv
// Bench for trx_sequencer: a sequential behavioural model checked every cycle,
// invariant checks, and directed scenarios with hand-computed expectations.
module tb_trx_sequencer;
  localparam int NB       = 6;
  localparam int TB_BREAK = 2;
  localparam int TB_BAND  = 4;
  localparam int TB_KEY   = 3;
  localparam int TB_UNKEY = 2;
  localparam int TB_RX    = 3;
  localparam int TB_TXMAX = 10;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       txReq = 1'b0;
  logic [2:0] bandReq = 3'd0;
  logic [5:0] bandSelect;
  logic       txEnable, ncoEnable, busy, badBand, txTimeout;
  logic [2:0] state;

  always #5 clk = ~clk;

  trx_sequencer #(
    .NUM_BANDS(NB), .CNT_W(16), .T_BREAK(TB_BREAK), .T_BAND(TB_BAND),
    .T_KEY(TB_KEY), .T_UNKEY(TB_UNKEY), .T_RX(TB_RX), .TX_MAX(TB_TXMAX)
  ) dut (
    .clk(clk), .rstN(rstN), .txReq(txReq), .bandReq(bandReq),
    .bandSelect(bandSelect), .txEnable(txEnable), .ncoEnable(ncoEnable),
    .busy(busy), .badBand(badBand), .txTimeout(txTimeout), .state(state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected outputs as a timeline of phases, advanced one clock edge at a time.
  int         m_band, m_state, s_band;
  logic [5:0] m_bs;
  bit         m_tx, m_nco, m_busy, m_bad, m_to, m_abort, s_tx;

  task automatic edge_m();
    @(posedge clk);
    if (!rstN) m_abort = 1'b1;
    else begin
      s_tx   = txReq;
      s_band = int'(bandReq);
      m_bad  = (s_band >= NB);
    end
  endtask

  task automatic m_band_switch(input int nb);
    m_state = 1; m_bs = '0; m_busy = 1'b1;
    repeat (TB_BREAK) begin edge_m(); if (m_abort) return; end
    m_state = 2; m_bs = 6'(1 << nb); m_band = nb;
    repeat (TB_BAND) begin edge_m(); if (m_abort) return; end
    m_state = 0; m_busy = 1'b0;
  endtask

  task automatic m_tx_cycle();
    bit dropped;
    int n;
    dropped = 1'b0;
    m_state = 3; m_tx = 1'b1; m_busy = 1'b1;
    for (int i = 0; i < TB_KEY; i++) begin
      edge_m(); if (m_abort) return;
      if (!s_tx) begin dropped = 1'b1; break; end
    end
    if (!dropped) begin
      m_state = 4; m_nco = 1'b1; n = 0;
      forever begin
        edge_m(); if (m_abort) return;
        n++;
        if (!s_tx) break;
        if (TB_TXMAX != 0 && n == TB_TXMAX) begin m_to = 1'b1; break; end
      end
    end
    m_state = 5; m_nco = 1'b0;
    repeat (TB_UNKEY) begin edge_m(); if (m_abort) return; end
    m_state = 6; m_tx = 1'b0;
    repeat (TB_RX) begin edge_m(); if (m_abort) return; end
    m_state = 0; m_busy = 1'b0;
  endtask

  initial begin : model
    forever begin
      m_abort = 1'b0; m_band = 0; m_bs = 6'b000001; m_tx = 1'b0; m_nco = 1'b0;
      m_busy = 1'b0; m_bad = 1'b0; m_to = 1'b0; m_state = 0;
      wait (rstN);
      while (!m_abort) begin
        edge_m();
        if (m_abort) break;
        if (s_band < NB && s_band != m_band) m_band_switch(s_band);
        else if (s_tx && !m_to) m_tx_cycle();
        else if (!s_tx) m_to = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model, plus structural invariants.
  logic [5:0] prev_bs;
  bit         prev_tx, prev_ok;
  always @(negedge clk) begin
    if (!rstN) prev_ok = 1'b0;
    else begin
      check("state", state, m_state);
      check("bandSelect", bandSelect, m_bs);
      check("txEnable", txEnable, m_tx);
      check("ncoEnable", ncoEnable, m_nco);
      check("busy", busy, m_busy);
      check("badBand", badBand, m_bad);
      check("txTimeout", txTimeout, m_to);
      if (ncoEnable) check("inv_nco_tx_on", {txEnable, state}, {1'b1, 3'd4});
      check("inv_onehot0", $onehot0(bandSelect), 1);
      check("inv_zero_only_break", (bandSelect == 6'b0), (state == 3'd1));
      if (prev_ok && prev_tx && txEnable) check("inv_band_hold_tx", bandSelect, prev_bs);
      prev_bs = bandSelect; prev_tx = txEnable; prev_ok = 1'b1;
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  int st_a[11] = '{1, 1, 2, 2, 2, 2, 0, 3, 3, 3, 4};
  int st_b[7]  = '{5, 5, 6, 6, 6, 0, 1};
  int nco_cnt;

  initial begin : stim
    repeat (3) nxt();
    rstN = 1'b1;
    repeat (5) nxt();
    check("rst_bandSelect", bandSelect, 6'b000001);
    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_tx", {txEnable, ncoEnable}, 2'b00);

    // Band 0 -> 3: two cycles dark, four cycles settling on band 3.
    bandReq = 3'd3;
    for (int i = 0; i < 7; i++) begin
      nxt();
      check("brk_state", state, (i < 2) ? 1 : (i < 6) ? 2 : 0);
      check("brk_bs", bandSelect, (i < 2) ? 6'b000000 : 6'b001000);
    end

    // Band change and TX request together: band first, then key-up.
    bandReq = 3'd5; txReq = 1'b1;
    for (int i = 0; i < 11; i++) begin
      nxt();
      check("seq_state", state, st_a[i]);
      check("seq_tx", txEnable, (i >= 7) ? 1 : 0);
      check("seq_nco", ncoEnable, (i == 10) ? 1 : 0);
    end

    // Band request during TX is deferred until after RX recovery.
    bandReq = 3'd2;
    repeat (3) nxt();
    check("on_state", state, 4);
    check("on_bs_kept", bandSelect, 6'b100000);
    txReq = 1'b0;
    for (int i = 0; i < 7; i++) begin
      nxt();
      check("unkey_state", state, st_b[i]);
      check("unkey_tx", txEnable, (i < 2) ? 1 : 0);
      check("unkey_nco", ncoEnable, 0);
    end
    repeat (6) nxt();
    check("deferred_band", bandSelect, 6'b000100);
    check("deferred_state", state, 0);

    // Watchdog: RF for exactly TX_MAX cycles, then locked out until txReq drops.
    txReq = 1'b1;
    nco_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      nxt();
      if (ncoEnable) nco_cnt++;
    end
    check("wd_nco_cycles", nco_cnt, 10);
    check("wd_timeout", txTimeout, 1);
    check("wd_locked_state", state, 0);
    check("wd_locked_tx", txEnable, 0);
    txReq = 1'b0;
    nxt();
    check("wd_cleared", txTimeout, 0);
    txReq = 1'b1;
    nxt();
    check("rekey_state", state, 3);
    txReq = 1'b0;
    nxt();
    check("keyup_abort", state, 5);
    repeat (6) nxt();
    check("abort_done", state, 0);

    // Out-of-range band index.
    bandReq = 3'd7;
    nxt();
    check("bad_flag", badBand, 1);
    check("bad_bs", bandSelect, 6'b000100);
    repeat (3) nxt();
    check("bad_state", state, 0);
    check("bad_bs_hold", bandSelect, 6'b000100);
    bandReq = 3'd2;
    nxt();
    check("bad_clear", badBand, 0);

    // Asynchronous reset while RF is on.
    txReq = 1'b1;
    repeat (6) nxt();
    check("pre_rst_nco", ncoEnable, 1);
    rstN = 1'b0;
    #1;
    check("arst_nco", ncoEnable, 0);
    check("arst_tx", txEnable, 0);
    check("arst_bs", bandSelect, 6'b000001);
    check("arst_state", state, 0);
    txReq = 1'b0; bandReq = 3'd0;
    nxt();
    rstN = 1'b1;
    repeat (5) nxt();
    check("post_rst_bs", bandSelect, 6'b000001);
    check("post_rst_state", state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : guard
    #200000;
    $display("FAIL time_limit: bench did not reach its end, got timeout expected finish");
    $fatal(1);
  end

endmodule
